// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD/FCS, checks CRC-32, error flag and frame length.
// Define GMII_RX_STATS_EN to build the saturating good/bad frame counters; otherwise they read 0.
module gmii_rx_deframer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        GMII_CLK,
    input  logic        RESET_N,
    input  logic        GMII_RX_DV,
    input  logic [7:0]  GMII_RXD,
    input  logic        GMII_RX_ER,
    output logic [7:0]  RX_DATA,
    output logic        RX_VALID,
    output logic        RX_LAST,
    output logic        RX_GOOD,
    output logic        RX_BAD,
    output logic [15:0] FRAME_OK_CNT,
    output logic [15:0] FRAME_ERR_CNT
);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t          state;
    logic            dv_r, dv_q, er_r;
    logic [7:0]      rxd_r;
    logic [3:0][7:0] dline;
    logic [10:0]     count;
    logic [31:0]     crc;
    logic            er_seen;
    logic            ovf_r;
    logic            out_vld;
    logic [7:0]      out_byte;

    logic eof, len_ok, frame_good;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    // DV history resets high so a DV already asserted at reset release is not taken as an edge.
    always_ff @(posedge GMII_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dv_r  <= 1'b1;
            dv_q  <= 1'b1;
            er_r  <= 1'b0;
            rxd_r <= 8'h00;
        end else begin
            dv_r  <= GMII_RX_DV;
            dv_q  <= dv_r;
            er_r  <= GMII_RX_ER;
            rxd_r <= GMII_RXD;
        end
    end

    always_ff @(posedge GMII_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            dline    <= '0;
            count    <= '0;
            crc      <= '1;
            er_seen  <= 1'b0;
            ovf_r    <= 1'b0;
            out_vld  <= 1'b0;
            out_byte <= 8'h00;
        end else begin
            out_vld <= 1'b0;
            ovf_r   <= 1'b0;
            case (state)
                IDLE: if (dv_r && !dv_q) state <= PREAMBLE;
                PREAMBLE: begin
                    if (!dv_r)
                        state <= IDLE;
                    else if (rxd_r == 8'hD5) begin
                        state   <= DATA;
                        count   <= '0;
                        crc     <= '1;
                        er_seen <= 1'b0;
                    end else if (rxd_r != 8'h55)
                        state <= DROP;
                end
                DATA: begin
                    if (!dv_r) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        dline <= {dline[2:0], rxd_r};
                        crc   <= crc_next(crc, rxd_r);
                        if (er_r) er_seen <= 1'b1;
                        if (count != '1) count <= count + 11'd1;
                        // Once four bytes are held, every push evicts the oldest one to the output.
                        if (count >= 11'd4) begin
                            out_vld  <= 1'b1;
                            out_byte <= dline[3];
                        end
                        if (int'(count) == MAX_LEN) begin
                            ovf_r <= 1'b1;
                            state <= DROP;
                            count <= '0;
                        end
                    end
                end
                DROP: if (!dv_r) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Frame end is only known one cycle after the last byte was evicted (DV seen low), so
    // status is decoded from registered state to keep the 5-cycle data latency.
    assign eof        = (state == DATA) && !dv_r;
    assign len_ok     = (int'(count) >= MIN_LEN) && (int'(count) <= MAX_LEN);
    assign frame_good = (crc == CRC_RESIDUE) && !er_seen && len_ok;

    assign RX_DATA  = out_byte;
    assign RX_VALID = out_vld;
    assign RX_LAST  = out_vld && (ovf_r || eof);
    assign RX_GOOD  = RX_LAST && !ovf_r && frame_good;
    assign RX_BAD   = RX_LAST && !RX_GOOD;

`ifdef GMII_RX_STATS_EN
    logic [15:0] ok_cnt, err_cnt;
    logic        ok_ev, err_ev;

    // A runt never reaches the output, and a bad preamble never reaches DATA: count both here.
    assign ok_ev  = RX_GOOD;
    assign err_ev = RX_BAD || (eof && (count <= 11'd4)) ||
                    ((state == PREAMBLE) && dv_r && (rxd_r != 8'h55) && (rxd_r != 8'hD5));

    always_ff @(posedge GMII_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (ok_ev && (ok_cnt != '1))   ok_cnt  <= ok_cnt + 16'd1;
            if (err_ev && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
        end
    end

    assign FRAME_OK_CNT  = ok_cnt;
    assign FRAME_ERR_CNT = err_cnt;
`else
    assign FRAME_OK_CNT  = '0;
    assign FRAME_ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Scoreboard bench for gmii_rx_deframer: stimulus pushes expected beats with due cycle, a monitor pops.
module tb_gmii_rx_deframer;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
`ifdef GMII_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       good;
        logic       bad;
        int         stamp;
    } beat_t;

    logic        GMII_CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        GMII_RX_DV = 1'b0;
    logic [7:0]  GMII_RXD = 8'h00;
    logic        GMII_RX_ER = 1'b0;
    logic [7:0]  RX_DATA;
    logic        RX_VALID, RX_LAST, RX_GOOD, RX_BAD;
    logic [15:0] FRAME_OK_CNT, FRAME_ERR_CNT;

    beat_t exp_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;

    gmii_rx_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .GMII_CLK(GMII_CLK), .RESET_N(RESET_N),
        .GMII_RX_DV(GMII_RX_DV), .GMII_RXD(GMII_RXD), .GMII_RX_ER(GMII_RX_ER),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_LAST(RX_LAST),
        .RX_GOOD(RX_GOOD), .RX_BAD(RX_BAD),
        .FRAME_OK_CNT(FRAME_OK_CNT), .FRAME_ERR_CNT(FRAME_ERR_CNT)
    );

    always #4 GMII_CLK = ~GMII_CLK;
    always @(posedge GMII_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, exp);
    endtask

    // Monitor: each due beat must appear exactly on its cycle with matching data and status.
    always @(negedge GMII_CLK) begin : mon
        beat_t b;
        if (RX_VALID) begin
            n_chk++;
            if (exp_q.size() == 0 || exp_q[0].stamp > cyc)
                $display("FAIL beat: unexpected data=%02h last=%0b at cycle %0d, no beat required", RX_DATA, RX_LAST, cyc);
            else begin
                b = exp_q.pop_front();
                if (RX_DATA === b.data && RX_LAST === b.last && RX_GOOD === b.good &&
                    RX_BAD === b.bad && b.stamp == cyc)
                    n_pass++;
                else
                    $display("FAIL beat: got data=%02h last=%0b good=%0b bad=%0b cyc=%0d, required data=%02h last=%0b good=%0b bad=%0b cyc=%0d",
                             RX_DATA, RX_LAST, RX_GOOD, RX_BAD, cyc, b.data, b.last, b.good, b.bad, b.stamp);
            end
        end else if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
            n_chk++;
            b = exp_q.pop_front();
            $display("FAIL beat: got no RX_VALID at cycle %0d, required data=%02h last=%0b", cyc, b.data, b.last);
        end
    end

    function automatic logic [31:0] fcs_of(input bq_t q);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (q[i])
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        return ~c;
    endfunction

    // n payload bytes seed, seed+1, ... followed by the FCS (first FCS byte optionally corrupted).
    function automatic bq_t make_frame(input int n, input int seed, input logic [7:0] fcs_xor);
        bq_t         q;
        logic [31:0] f;
        for (int i = 0; i < n; i++) q.push_back(8'(seed + i));
        f = fcs_of(q);
        q.push_back(f[7:0] ^ fcs_xor);
        q.push_back(f[15:8]);
        q.push_back(f[23:16]);
        q.push_back(f[31:24]);
        return q;
    endfunction

    task automatic drive(input logic dv, input logic [7:0] d);
        @(negedge GMII_CLK);
        GMII_RX_DV = dv;
        GMII_RXD   = d;
        GMII_RX_ER = 1'b0;
    endtask

    task automatic send_frame(input bq_t pre, input bq_t body, input bit sfd_ok, input bit exp_good,
                              input int er_idx, input int rst_at, input int gap);
        int nb, n_out;
        bit aborted;
        nb      = body.size();
        n_out   = !sfd_ok ? 0 : (nb <= 4) ? 0 : (nb > MAX_LEN) ? MAX_LEN - 3 : nb - 4;
        aborted = 1'b0;
        foreach (pre[i]) drive(1'b1, pre[i]);
        for (int k = 0; k < nb; k++) begin
            @(negedge GMII_CLK);
            GMII_RX_DV = 1'b1;
            GMII_RXD   = body[k];
            GMII_RX_ER = (k == er_idx);
            if (!aborted && k < n_out)
                exp_q.push_back('{body[k], (k == n_out - 1), (k == n_out - 1) && exp_good,
                                  (k == n_out - 1) && !exp_good, cyc + 6});
            if (k == rst_at) begin
                #2 RESET_N = 1'b0;
                #1;
                check("valid_drop_on_reset", 32'(RX_VALID), 32'h0);
                check("no_last_on_reset", 32'(RX_LAST), 32'h0);
                exp_q.delete();
                aborted = 1'b1;
            end
            if (rst_at >= 0 && k == rst_at + 3) RESET_N = 1'b1;
        end
        repeat (gap) drive(1'b0, 8'h00);
    endtask

    task automatic check_counts(input int ok, input int err);
        repeat (2) @(negedge GMII_CLK);
        check("frame_ok_cnt", 32'(FRAME_OK_CNT), STATS ? 32'(ok) : 32'h0);
        check("frame_err_cnt", 32'(FRAME_ERR_CNT), STATS ? 32'(err) : 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t pre, bad_pre, tiny;
        pre     = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
        bad_pre = '{8'h55, 8'h55, 8'hAA};
        tiny    = '{8'h01, 8'h02, 8'h03};

        repeat (3) @(negedge GMII_CLK);
        check("rst_valid", 32'(RX_VALID), 32'h0);
        check("rst_last", 32'(RX_LAST), 32'h0);
        check("rst_good", 32'(RX_GOOD), 32'h0);
        check("rst_bad", 32'(RX_BAD), 32'h0);
        check("rst_data", 32'(RX_DATA), 32'h0);
        check("rst_ok_cnt", 32'(FRAME_OK_CNT), 32'h0);
        check("rst_err_cnt", 32'(FRAME_ERR_CNT), 32'h0);
        @(negedge GMII_CLK) RESET_N = 1'b1;
        repeat (3) drive(1'b0, 8'h00);

        send_frame(pre, make_frame(60, 0, 8'h00), 1'b1, 1'b1, -1, -1, 4);     // good 64-byte frame
        check_counts(1, 0);
        send_frame(pre, make_frame(60, 0, 8'h01), 1'b1, 1'b0, -1, -1, 4);     // corrupted FCS
        check_counts(1, 1);
        send_frame(pre, make_frame(60, 0, 8'h00), 1'b1, 1'b0, 10, -1, 4);     // RX_ER on byte 10
        check_counts(1, 2);
        send_frame(pre, make_frame(36, 8'h40, 8'h00), 1'b1, 1'b0, -1, -1, 4); // 40-byte runt
        check_counts(1, 3);
        send_frame(pre, tiny, 1'b1, 1'b0, -1, -1, 4);                         // 3 bytes: dropped
        check_counts(1, 4);
        send_frame(bad_pre, make_frame(60, 0, 8'h00), 1'b0, 1'b0, -1, -1, 4); // bad preamble
        check_counts(1, 5);
        send_frame(pre, make_frame(60, 8'h80, 8'h00), 1'b1, 1'b1, -1, -1, 1); // one-cycle DV gap
        send_frame(pre, make_frame(60, 8'hC0, 8'h00), 1'b1, 1'b1, -1, -1, 4);
        check_counts(3, 5);
        send_frame(pre, make_frame(1596, 0, 8'h00), 1'b1, 1'b0, -1, -1, 4);   // 1600 bytes: overflow
        check_counts(3, 6);
        send_frame(pre, make_frame(60, 0, 8'h00), 1'b1, 1'b1, -1, 20, 4);     // reset mid-frame
        check_counts(0, 0);
        send_frame(pre, make_frame(60, 0, 8'h00), 1'b1, 1'b1, -1, -1, 4);
        check_counts(1, 0);

        repeat (10) drive(1'b0, 8'h00);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
